// File: rtl/dsp48a1_mac_sequencer.sv
// ---------------------------------------------------------------------------
// dsp48a1_mac_sequencer
//
// Dot-product controller for one DSP48A1 slice in multiply-accumulate mode.
// A command carries the vector length. The block then streams A/B sample pairs
// into the slice and waits out the slice pipeline. It returns the 48-bit
// accumulated P through a result handshake.
//
// Required slice strapping: A0REG=0 A1REG=1 B0REG=0 B1REG=1 MREG=1 PREG=1
// OPMODEREG=1 CARRYINREG=1 CARRYINSEL="OPMODE5" B_INPUT="DIRECT" RSTTYPE="SYNC".
//
// Parameters
//   LEN_W     width of cmd_len (max vector length 2**LEN_W-1)
//   SUBTRACT  1: accumulate P - A*B, 0: accumulate P + A*B
//
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   cmd_valid/ready     command handshake, cmd_len = number of pairs
//   s_valid/ready       sample-pair handshake, s_a/s_b signed 18-bit
//   r_valid/ready       result handshake, r_data = accumulated P
//   busy                high whenever the sequencer is not idle
//   dsp_a, dsp_b        slice A/B inputs (combinational from s_a/s_b)
//   dsp_ce*             slice clock enables
//   dsp_opmode          slice OPMODE
//   dsp_rst             drives every slice RST* input
//   dsp_p               slice P output
// ---------------------------------------------------------------------------
module dsp48a1_mac_sequencer #(
  parameter int LEN_W    = 16,
  parameter bit SUBTRACT = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [17:0]  s_a,
  input  logic signed [17:0]  s_b,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [47:0]         r_data,
  output logic                busy,
  output logic signed [17:0]  dsp_a,
  output logic signed [17:0]  dsp_b,
  output logic                dsp_cea,
  output logic                dsp_ceb,
  output logic                dsp_cem,
  output logic                dsp_cep,
  output logic                dsp_ceopmode,
  output logic                dsp_cecarryin,
  output logic [7:0]          dsp_opmode,
  output logic                dsp_rst,
  input  logic [47:0]         dsp_p
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             first;
  logic             rst_d;

  logic             cmd_fire;
  logic             s_fire;

  // Per-pair tag pipeline: _p0 marks the multiply cycle, _p1 the P-update cycle.
  logic             vld_p0;
  logic             first_p0;
  logic             vld_p1;

  // OPMODE for the multiply cycle of an issued pair.
  // Z = 0 for the first pair of a vector (clears the accumulator), Z = P
  // otherwise; X = M always. No pre-adder, carry-in 0, bit 7 picks add/sub.
  function automatic logic [7:0] opmode_sel(input logic issued, input logic is_first);
    logic [7:0] op;
    op = 8'h00;
    if (issued) begin
      op[7]   = SUBTRACT;
      op[3:2] = is_first ? 2'b00 : 2'b10;
      op[1:0] = 2'b01;
    end
    return op;
  endfunction

  // Handshake decode. Everything is forced low while RST is high, because the
  // state register only returns to IDLE at the next edge.
  assign cmd_ready = !RST && (state == S_IDLE);
  assign s_ready   = !RST && (state == S_RUN) && (cnt != '0);
  assign r_valid   = !RST && (state == S_DONE);
  assign busy      = !RST && (state != S_IDLE);

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign s_fire    = s_valid && s_ready;

  // Slice data inputs pass straight through; A1/B1 inside the slice register them.
  assign dsp_a     = s_a;
  assign dsp_b     = s_b;

  // Slice control
  assign dsp_cea        = s_fire;
  assign dsp_ceb        = s_fire;
  assign dsp_cem        = !RST && vld_p0;
  assign dsp_cep        = !RST && vld_p1;
  assign dsp_opmode     = opmode_sel(!RST && vld_p0, first_p0);
  assign dsp_ceopmode   = !RST;
  assign dsp_cecarryin  = 1'b0;

  // Slice reset is stretched one cycle past RST so the slice sees a full
  // reset edge after ours.
  assign dsp_rst        = RST || rst_d;

  always_ff @(posedge CLK) begin
    rst_d <= RST;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      first    <= 1'b0;
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      vld_p1   <= 1'b0;
      r_data   <= '0;
    end else begin
      // --- stage p0: pair accepted last cycle, M register loads ---
      vld_p0   <= s_fire;
      first_p0 <= s_fire && first;
      // --- stage p1: P register loads ---
      vld_p1   <= vld_p0;

      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            cnt <= cmd_len;
            if (cmd_len == '0) begin
              // Empty vector: report zero without touching the slice.
              r_data <= '0;
              state  <= S_DONE;
            end else begin
              first <= 1'b1;
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (s_fire) begin
            cnt   <= cnt - LEN_W'(1);
            first <= 1'b0;
            if (cnt == LEN_W'(1)) begin
              state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // Both tag stages empty means the last CEP has fired and dsp_p
          // now holds the final sum.
          if (!vld_p0 && !vld_p1) begin
            r_data <= dsp_p;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          if (r_ready) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dsp48a1_mac_sequencer
//
// Drives dsp48a1_mac_sequencer against a behavioural DSP48A1 slice model.
// Results are compared with a plain sum-of-products reference over the pairs
// sent for each command.
// ---------------------------------------------------------------------------
module tb_dsp48a1_mac_sequencer;

  localparam int LEN_W    = 16;
  localparam bit SUBTRACT = 1'b0;

  logic                CLK = 1'b0;
  logic                RST;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [LEN_W-1:0]    cmd_len;
  logic                s_valid;
  logic                s_ready;
  logic signed [17:0]  s_a;
  logic signed [17:0]  s_b;
  logic                r_valid;
  logic                r_ready;
  logic [47:0]         r_data;
  logic                busy;
  logic signed [17:0]  dsp_a;
  logic signed [17:0]  dsp_b;
  logic                dsp_cea, dsp_ceb, dsp_cem, dsp_cep;
  logic                dsp_ceopmode, dsp_cecarryin;
  logic [7:0]          dsp_opmode;
  logic                dsp_rst;
  logic [47:0]         dsp_p;

  always #5 CLK = ~CLK;

  dsp48a1_mac_sequencer #(.LEN_W(LEN_W), .SUBTRACT(SUBTRACT)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .busy(busy),
    .dsp_a(dsp_a), .dsp_b(dsp_b),
    .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem), .dsp_cep(dsp_cep),
    .dsp_ceopmode(dsp_ceopmode), .dsp_cecarryin(dsp_cecarryin),
    .dsp_opmode(dsp_opmode), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
  );

  // ---------------- behavioural DSP48A1 slice (strapping as required) -------
  logic signed [17:0] sl_a1, sl_b1;
  logic signed [35:0] sl_m;
  logic [7:0]         sl_op;
  logic signed [47:0] sl_p;

  function automatic logic signed [47:0] post_add(input logic [7:0] op,
                                                  input logic signed [35:0] mm,
                                                  input logic signed [47:0] pp);
    logic signed [47:0] x, z;
    x = (op[1:0] == 2'b01) ? {{12{mm[35]}}, mm} : 48'sd0;
    z = (op[3:2] == 2'b10) ? pp : 48'sd0;
    return op[7] ? (z - x) : (z + x);
  endfunction

  always @(posedge CLK) begin
    if (dsp_rst) begin
      sl_a1 <= '0; sl_b1 <= '0; sl_m <= '0; sl_op <= '0; sl_p <= '0;
    end else begin
      if (dsp_cea)      sl_a1 <= dsp_a;
      if (dsp_ceb)      sl_b1 <= dsp_b;
      if (dsp_cem)      sl_m  <= sl_a1 * sl_b1;
      if (dsp_ceopmode) sl_op <= dsp_opmode;
      if (dsp_cep)      sl_p  <= post_add(sl_op, sl_m, sl_p);
    end
  end
  assign dsp_p = sl_p;

  // ---------------- monitors ------------------------------------------------
  int cyc = 0;
  int cep_cnt = 0;
  int ce_cnt = 0;
  int viol = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (dsp_cep) cep_cnt <= cep_cnt + 1;
    if (dsp_cea || dsp_ceb || dsp_cem || dsp_cep) ce_cnt <= ce_cnt + 1;
    // OPMODE must be idle without a multiply cycle, never use the pre-adder
    // or carry-in, and CEOPMODE follows reset.
    if ((!dsp_cem && dsp_opmode != 8'h00) || dsp_opmode[6:4] != 3'b000 ||
        dsp_cecarryin || (dsp_ceopmode == RST) ||
        (RST && (dsp_cea || dsp_ceb || dsp_cem || dsp_cep)))
      viol <= viol + 1;
  end

  // ---------------- checking ------------------------------------------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic abort_timeout(input string tag);
    chk(tag, 64'd0, 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  endtask

  // ---------------- reference model -----------------------------------------
  int pa[$];
  int pb[$];

  function automatic logic [47:0] ref_dot(input int n);
    longint acc;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (SUBTRACT) acc -= longint'(pa[i]) * longint'(pb[i]);
      else          acc += longint'(pa[i]) * longint'(pb[i]);
    end
    return acc[47:0];
  endfunction

  // ---------------- stimulus tasks (entered at posedge+1) -------------------
  task automatic send_cmd(input int len, output int t_acc);
    int n;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    n = 0;
    forever begin
      @(negedge CLK);
      if (cmd_ready) break;
      n++;
      if (n > 50) abort_timeout("cmd_accept_timeout");
      @(posedge CLK); #1;
    end
    t_acc = cyc;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    cmd_len   = LEN_W'($urandom);
  endtask

  task automatic send_pair(input int a, input int b, input int nb, output int t_acc);
    int n;
    repeat (nb) begin
      s_valid = 1'b0;
      s_a = 18'($urandom);
      s_b = 18'($urandom);
      @(posedge CLK); #1;
    end
    s_valid = 1'b1;
    s_a = 18'(a);
    s_b = 18'(b);
    n = 0;
    forever begin
      @(negedge CLK);
      if (s_ready) break;
      n++;
      if (n > 50) abort_timeout("pair_accept_timeout");
      @(posedge CLK); #1;
    end
    t_acc = cyc;
    @(posedge CLK); #1;
    s_valid = 1'b0;
  endtask

  // bub < 0 selects random 0..3 bubbles per pair.
  task automatic run_cmd(input int len, input int bub, input int hold,
                         output logic [47:0] res, output int lat);
    int t_acc, n, nb;
    send_cmd(len, t_acc);
    for (int i = 0; i < len; i++) begin
      nb = (bub < 0) ? int'($urandom_range(0, 3)) : bub;
      send_pair(pa[i], pb[i], nb, t_acc);
    end
    n = 0;
    forever begin
      @(negedge CLK);
      if (r_valid) break;
      n++;
      if (n > 50) abort_timeout("result_timeout");
    end
    lat = cyc - t_acc;
    res = r_data;
    repeat (hold) begin
      chk("hold_r_data", 64'(r_data), 64'(res));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_r_valid", 64'(r_valid), 64'd1);
      @(negedge CLK);
    end
    r_ready = 1'b1;
    @(posedge CLK); #1;
    r_ready = 1'b0;
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    logic [47:0] res;
    logic signed [17:0] tmp;
    int lat, c0, t0, len;

    RST = 1'b1; cmd_valid = 1'b0; cmd_len = '0; s_valid = 1'b0;
    s_a = '0; s_b = '0; r_ready = 1'b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_r_data", 64'(r_data), 64'd0);
    chk("rst_opmode", 64'(dsp_opmode), 64'd0);
    chk("rst_ce", 64'({dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_cecarryin}), 64'd0);
    chk("rst_dsp_rst", 64'(dsp_rst), 64'd1);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_stretch", 64'(dsp_rst), 64'd1);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge CLK);
    chk("rst_released", 64'(dsp_rst), 64'd0);
    @(posedge CLK); #1;

    // 1: three pairs, no bubbles
    pa = '{2, 4, -1}; pb = '{3, 5, 7};
    run_cmd(3, 0, 0, res, lat);
    chk("t1_result", 64'(res), 64'(ref_dot(3)));
    chk("t1_latency", 64'(lat), 64'd4);

    // 2: same vector, two bubbles between pairs
    c0 = cep_cnt;
    run_cmd(3, 2, 0, res, lat);
    chk("t2_result", 64'(res), 64'(ref_dot(3)));
    chk("t2_cep_pulses", 64'(cep_cnt - c0), 64'd3);
    chk("t2_latency", 64'(lat), 64'd4);

    // 3: most-negative squared, then a fresh vector must not inherit P
    pa = '{-131072}; pb = '{-131072};
    run_cmd(1, 0, 0, res, lat);
    chk("t3_neg_square", 64'(res), 64'(ref_dot(1)));
    pa = '{1, 1}; pb = '{1, 1};
    run_cmd(2, 0, 0, res, lat);
    chk("t3_first_clears", 64'(res), 64'(ref_dot(2)));

    // 4: empty vector
    c0 = ce_cnt;
    run_cmd(0, 0, 0, res, lat);
    chk("t4_result", 64'(res), 64'd0);
    chk("t4_latency", 64'(lat), 64'd1);
    chk("t4_no_ce", 64'(ce_cnt - c0), 64'd0);

    // 5: result held for 10 cycles
    pa = '{100, -7, 3}; pb = '{-5, 9, 11};
    run_cmd(3, 1, 10, res, lat);
    chk("t5_result", 64'(res), 64'(ref_dot(3)));
    @(negedge CLK);
    chk("t5_back_idle", 64'(cmd_ready), 64'd1);
    chk("t5_not_busy", 64'(busy), 64'd0);
    @(posedge CLK); #1;

    // 6: reset after 2 of 5 pairs
    send_cmd(5, t0);
    send_pair(7, 8, 0, t0);
    send_pair(-9, 10, 0, t0);
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_dsp_rst", 64'(dsp_rst), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_s_ready", 64'(s_ready), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("t6_rst_stretch", 64'(dsp_rst), 64'd1);
    chk("t6_idle", 64'(cmd_ready), 64'd1);
    c0 = 0;
    repeat (10) begin
      @(negedge CLK);
      if (r_valid) c0++;
    end
    chk("t6_no_result", 64'(c0), 64'd0);
    @(posedge CLK); #1;
    pa = '{3}; pb = '{3};
    run_cmd(1, 0, 0, res, lat);
    chk("t6_fresh", 64'(res), 64'(ref_dot(1)));

    // random vectors with random bubbles and result back-pressure
    for (int k = 0; k < 12; k++) begin
      len = int'($urandom_range(1, 8));
      pa.delete(); pb.delete();
      for (int i = 0; i < len; i++) begin
        tmp = 18'($urandom);
        pa.push_back(int'(tmp));
        tmp = 18'($urandom);
        pb.push_back(int'(tmp));
      end
      run_cmd(len, -1, int'($urandom_range(0, 3)), res, lat);
      chk("rand_result", 64'(res), 64'(ref_dot(len)));
      chk("rand_latency", 64'(lat), 64'd4);
    end

    @(negedge CLK);
    chk("slice_ctrl_rules", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
